// File: rtl/rr_stream_multiplexer_pkg.sv
// rr_stream_multiplexer_pkg: shared FSM state type and modulo helper for the stream multiplexer
package rr_stream_multiplexer_pkg;
  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
  function automatic int mod_add(input int a, input int b, input int n);
    return (a + b >= n) ? a + b - n : a + b;
  endfunction
endpackage

// File: rtl/rr_stream_multiplexer_if.sv
// rr_stream_multiplexer_if: N input streams plus one merged output stream with source index
interface rr_stream_multiplexer_if #(
  parameter int N_STREAMS = 2,
  parameter type DATA_TYPE = logic [63:0]
);
  localparam int N_BITS = $clog2(N_STREAMS);
  DATA_TYPE i_data [N_STREAMS];
  logic [N_STREAMS-1:0] i_last;
  logic [N_STREAMS-1:0] i_valid;
  logic [N_STREAMS-1:0] i_ready;
  DATA_TYPE o_data;
  logic o_last;
  logic [N_BITS-1:0] o_select;
  logic o_valid;
  logic o_ready;
  modport slave (
    input i_data, i_last, i_valid, o_ready,
    output i_ready, o_data, o_last, o_select, o_valid
  );
  modport master (
    output i_data, i_last, i_valid, o_ready,
    input i_ready, o_data, o_last, o_select, o_valid
  );
endinterface

// File: rtl/rr_stream_multiplexer_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after a base index
module rr_arbiter import rr_stream_multiplexer_pkg::*; #(
  parameter int N = 2,
  localparam int NB = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [NB-1:0] i_base,
  output logic [NB-1:0] o_idx,
  output logic          o_valid
);
  // scan from the far end back toward i_base so the nearest requester is written last and wins
  always_comb begin
    o_idx = '0;
    o_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[NB'(mod_add(int'(i_base), i, N))]) begin
        o_idx = NB'(mod_add(int'(i_base), i, N));
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_stream_multiplexer.sv
// rr_stream_multiplexer: round-robin N-to-1 stream merge with per-packet grant lock and registered output
module rr_stream_multiplexer import rr_stream_multiplexer_pkg::*; #(
  parameter int N_STREAMS = 2,
  parameter type DATA_TYPE = logic [63:0],
  parameter bit PACKET_MODE = 1'b1,
  localparam int N_BITS = $clog2(N_STREAMS)
) (
  input logic clk,
  input logic rst,
  rr_stream_multiplexer_if.slave bus
);
  state_t r_state, w_next_state;
  logic [N_BITS-1:0] r_rr_ptr, r_locked_idx, w_arb_idx, w_grant_idx;
  logic w_arb_valid, w_grant_valid, w_load, w_accept, w_last;
  DATA_TYPE w_data;
  rr_arbiter #(.N(N_STREAMS)) u_arb (
    .i_req(bus.i_valid),
    .i_base(r_rr_ptr),
    .o_idx(w_arb_idx),
    .o_valid(w_arb_valid)
  );
  assign w_load = !bus.o_valid | bus.o_ready;
  assign w_accept = w_load & w_grant_valid & !rst;
  assign w_last = !PACKET_MODE | bus.i_last[w_grant_idx];
  assign w_data = bus.i_data[w_grant_idx];
  assign bus.i_ready = w_accept ? N_STREAMS'(1) << w_grant_idx : '0;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else r_state <= w_next_state;
  end
  // lock on a non-final beat, release on the final one; with PACKET_MODE=0 every beat is final
  always_comb w_next_state = w_accept ? (w_last ? ST_IDLE : ST_LOCKED) : r_state;
  // grant follows the locked stream mid-packet, otherwise the round-robin arbiter
  always_comb begin
    w_grant_idx = (r_state == ST_LOCKED) ? r_locked_idx : w_arb_idx;
    w_grant_valid = (r_state == ST_LOCKED) ? bus.i_valid[r_locked_idx] : w_arb_valid;
  end
  // output control register plus round-robin pointer and lock index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.o_valid <= 1'b0;
      bus.o_last <= 1'b0;
      bus.o_select <= '0;
      r_rr_ptr <= '0;
      r_locked_idx <= '0;
    end else begin
      if (w_load) bus.o_valid <= w_accept;
      if (w_accept) begin
        bus.o_last <= w_last;
        bus.o_select <= w_grant_idx;
        r_locked_idx <= w_grant_idx;
        if (w_last) r_rr_ptr <= N_BITS'(mod_add(int'(w_grant_idx), 1, N_STREAMS));
      end
    end
  end
  // payload register needs no reset since o_valid qualifies it
  always_ff @(posedge clk) begin
    if (w_accept) bus.o_data <= w_data;
  end
endmodule

// File: tb/tb_rr_stream_multiplexer.sv
// tb_rr_stream_multiplexer: randomized scoreboard bench against a packet-level round-robin model
module tb_rr_stream_multiplexer;
  localparam int N = 3;
  typedef logic [63:0] data_t;
  typedef struct {int sel; data_t data; logic last;} beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rr_stream_multiplexer_if #(.N_STREAMS(N)) bus ();
  rr_stream_multiplexer #(.N_STREAMS(N), .PACKET_MODE(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  rr_stream_multiplexer_if #(.N_STREAMS(4)) bus4 ();
  rr_stream_multiplexer #(.N_STREAMS(4), .PACKET_MODE(1'b0)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  int checks = 0;
  int failures = 0;
  beat_t sq [N][$];
  beat_t sb [$];
  int seq = 0;
  bit m_ov = 0;
  bit m_lock = 0;
  int m_li = 0;
  int m_ptr = 0;
  task automatic check(input string name, input data_t act, input data_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic push_pkt(input int k, input int len);
    for (int b = 0; b < len; b++) begin
      sq[k].push_back('{sel: k, data: {32'(k), 32'(seq)}, last: (b == len - 1)});
      seq++;
    end
  endtask
  // one cycle: drive inputs, predict the grant from the arbitration rules, record accepted beats
  task automatic step(input bit gen, input bit rdy);
    bit gv, load, acc;
    int gi;
    logic [N-1:0] exp_r;
    beat_t b;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (gen && sq[k].size() == 0 && $urandom_range(0, 3) != 0) push_pkt(k, $urandom_range(1, 4));
      bus.i_valid[k] = sq[k].size() > 0 && (!gen || $urandom_range(0, 4) != 0);
      bus.i_data[k] = sq[k].size() > 0 ? sq[k][0].data : {$urandom, $urandom};
      bus.i_last[k] = sq[k].size() > 0 ? sq[k][0].last : 1'($urandom_range(0, 1));
    end
    bus.o_ready = rdy;
    #1;
    gv = 0;
    gi = 0;
    if (m_lock) begin
      gi = m_li;
      gv = bus.i_valid[m_li];
    end else begin
      for (int j = 0; j < N; j++) begin
        if (!gv && bus.i_valid[(m_ptr + j) % N]) begin
          gi = (m_ptr + j) % N;
          gv = 1;
        end
      end
    end
    load = !m_ov || rdy;
    acc = load && gv;
    exp_r = acc ? N'(1) << gi : '0;
    check("o_valid", data_t'(bus.o_valid), data_t'(m_ov));
    check("i_ready", data_t'(bus.i_ready), data_t'(exp_r));
    if (load) m_ov = acc;
    if (acc) begin
      b = sq[gi].pop_front();
      sb.push_back(b);
      if (b.last) begin
        m_lock = 0;
        m_ptr = (gi + 1) % N;
      end else begin
        m_lock = 1;
        m_li = gi;
      end
    end
  endtask
  // asynchronous reset in the middle of a cycle; partial packets are abandoned
  task automatic do_reset();
    @(negedge clk);
    #3;
    bus.i_valid = '1;
    rst = 1'b1;
    #1;
    check("async_o_valid", data_t'(bus.o_valid), 0);
    check("rst_i_ready", data_t'(bus.i_ready), 0);
    @(negedge clk);
    #1;
    check("rst_i_ready_hold", data_t'(bus.i_ready), 0);
    bus.i_valid = '0;
    rst = 1'b0;
    sb.delete();
    for (int k = 0; k < N; k++) sq[k].delete();
    m_ov = 0;
    m_lock = 0;
    m_li = 0;
    m_ptr = 0;
  endtask
  // monitor: pop and compare on every output transfer, and require a stalled beat to stay stable
  bit prev_hold = 0;
  data_t p_data;
  int p_sel;
  logic p_last;
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      #2;
      if (rst) prev_hold = 0;
      else begin
        if (prev_hold) begin
          check("hold_valid", data_t'(bus.o_valid), 1);
          check("hold_data", bus.o_data, p_data);
          check("hold_select", data_t'(bus.o_select), data_t'(p_sel));
          check("hold_last", data_t'(bus.o_last), data_t'(p_last));
        end
        if (bus.o_valid && bus.o_ready) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL out_unexpected actual=%h expected=none", bus.o_data);
          end else begin
            b = sb.pop_front();
            if (bus.o_data !== b.data || int'(bus.o_select) != b.sel || bus.o_last !== b.last) begin
              failures++;
              $display("FAIL out_beat actual=%0d/%h/%0d expected=%0d/%h/%0d",
                       bus.o_select, bus.o_data, bus.o_last, b.sel, b.data, b.last);
            end
          end
        end
        prev_hold = bus.o_valid && !bus.o_ready;
        p_data = bus.o_data;
        p_sel = int'(bus.o_select);
        p_last = bus.o_last;
      end
    end
  end
  initial begin
    bus.i_valid = '0;
    bus.i_last = '0;
    bus.o_ready = 1'b0;
    for (int k = 0; k < N; k++) bus.i_data[k] = '0;
    bus4.i_valid = '0;
    bus4.i_last = '0;
    bus4.o_ready = 1'b0;
    for (int k = 0; k < 4; k++) bus4.i_data[k] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) step(0, 1);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      bus4.i_valid = '1;
      bus4.o_ready = 1'b1;
      for (int k = 0; k < 4; k++) bus4.i_data[k] = 64'h10 + 64'(k);
      #2;
      check("b_i_ready", data_t'(bus4.i_ready), data_t'(4'(1) << (c % 4)));
      check("b_o_valid", data_t'(bus4.o_valid), data_t'(c > 0));
      if (c > 0) begin
        check("b_select", data_t'(bus4.o_select), data_t'((c - 1) % 4));
        check("b_data", bus4.o_data, 64'h10 + data_t'((c - 1) % 4));
        check("b_last_forced", data_t'(bus4.o_last), 1);
      end
    end
    @(negedge clk);
    bus4.i_valid = '0;
    push_pkt(0, 3);
    push_pkt(1, 1);
    push_pkt(2, 1);
    repeat (8) step(0, 1);
    push_pkt(2, 1);
    repeat (2) step(0, 1);
    push_pkt(0, 1);
    push_pkt(1, 1);
    repeat (4) step(0, 1);
    push_pkt(0, 2);
    push_pkt(1, 2);
    repeat (2) step(0, 1);
    repeat (6) step(0, 0);
    repeat (6) step(0, 1);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 1500; c++) step(1, (c % 200) < 190 ? $urandom_range(0, 3) != 0 : 1'b0);
      do_reset();
      push_pkt(1, 1);
      push_pkt(2, 1);
      push_pkt(0, 1);
      repeat (5) step(0, 1);
    end
    for (int c = 0; c < 1000; c++) step(1, $urandom_range(0, 3) != 0);
    for (int c = 0; c < 40; c++) step(0, 1);
    check("drain_empty", data_t'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
